uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART RX path. It detects the start-bit edge and runs the per-bit edge counter that drives the 3-sample majority data sampler. It consumes the sampler's `sampled_bit` to check start, data, parity and stop bits, deserialises the frame LSB-first, and presents `p_data` with a one-cycle `data_valid` strobe or an error pulse.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_edge_bit_cnt.sv | 57 +++++
 rtl/uart_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX controller.
package uart_rx_pkg;

  // Width of edge_cnt and of the prescale input.
  localparam int unsigned PsWidth = 5;

  // Parity type encodings on par_typ.
  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit edge counter and data-bit counter for the UART RX controller.
// edge_cnt runs 0..P-1 while enabled; bit_cnt counts completed bits while bit_en_i is high.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int unsigned CntWidth = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic                bit_en_i,
  input  logic [PsWidth-1:0]  prescale_i,
  output logic [PsWidth-1:0]  edge_cnt_o,
  output logic [CntWidth-1:0] bit_cnt_o,
  output logic                last_edge_o
);

  logic [PsWidth-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CntWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic                last_edge;

  assign last_edge = en_i && (edge_cnt_q == (prescale_i - PsWidth'(1)));

  // Next-state: wrap the edge counter at P-1, bump the bit counter on each wrap.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!en_i) begin
      edge_cnt_d = '0;
    end else if (last_edge) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + PsWidth'(1);
    end
    if (!en_i || !bit_en_i) begin
      bit_cnt_d = '0;
    end else if (last_edge) begin
      bit_cnt_d = bit_cnt_q + CntWidth'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o  = edge_cnt_q;
  assign bit_cnt_o   = bit_cnt_q;
  assign last_edge_o = last_edge;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: start detection, bit sequencing, LSB-first deserialisation and
// frame checking. Define UART_RX_PARITY_EN to add the parity bit, par_en/par_typ ports
// and par_err logic; otherwise frames are start + DATA_WIDTH + stop and par_err is 0.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PsWidth-1:0]    prescale,
  input  logic                  sampled_bit,
`ifdef UART_RX_PARITY_EN
  input  logic                  par_en,
  input  logic                  par_typ,
`endif
  output logic [PsWidth-1:0]    edge_cnt,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_err
);

  localparam int unsigned BcW = $clog2(DATA_WIDTH + 1);

  rx_state_e             state_q, state_d;
  logic [PsWidth-1:0]    ps_q, ps_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  stp_err_q, stp_err_d;
  logic                  strt_err_q, strt_err_d;

  logic                  start_det;
  logic                  cnt_en;
  logic                  bit_en;
  logic [PsWidth-1:0]    ps_eff;
  logic [BcW-1:0]        bit_cnt;
  logic                  last_edge;
  logic                  par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_flag_q, par_flag_d;
  logic par_err_q, par_err_d;
  assign par_bad = par_flag_q;
  assign par_err = par_err_q;
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

  // The detection cycle is edge 0, so the counter runs during it using the live prescale.
  assign start_det   = (state_q == StIdle) && !rx_in;
  assign cnt_en      = (state_q != StIdle) || start_det;
  assign bit_en      = (state_q == StData);
  assign ps_eff      = (state_q == StIdle) ? prescale : ps_q;
  assign dat_samp_en = (state_q != StIdle);

  uart_rx_edge_bit_cnt #(
    .CntWidth (BcW)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .en_i        (cnt_en),
    .bit_en_i    (bit_en),
    .prescale_i  (ps_eff),
    .edge_cnt_o  (edge_cnt),
    .bit_cnt_o   (bit_cnt),
    .last_edge_o (last_edge)
  );

  // FSM next-state, shift register and output strobes.
  always_comb begin
    state_d      = state_q;
    ps_d         = ps_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    stp_err_d    = 1'b0;
    strt_err_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_flag_d   = par_flag_q;
    par_err_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (!rx_in) begin
          state_d = StStart;
          ps_d    = prescale;
`ifdef UART_RX_PARITY_EN
          par_flag_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (last_edge) begin
          if (sampled_bit) begin
            strt_err_d = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (last_edge) begin
          shreg_d = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
          if (bit_cnt == BcW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = par_en ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (last_edge) begin
          par_flag_d = sampled_bit != ((^shreg_q) ^ (par_typ == ParOdd));
          state_d    = StStop;
        end
      end
`endif
      StStop: begin
        if (last_edge) begin
          state_d   = StIdle;
          stp_err_d = !sampled_bit;
`ifdef UART_RX_PARITY_EN
          par_err_d = par_flag_q;
`endif
          if (sampled_bit && !par_bad) begin
            p_data_d     = shreg_q;
            data_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ps_q         <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      stp_err_q    <= 1'b0;
      strt_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ps_q         <= ps_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      stp_err_q    <= stp_err_d;
      strt_err_q   <= strt_err_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity flag and parity-error strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_flag_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      par_flag_q <= par_flag_d;
      par_err_q  <= par_err_d;
    end
  end
`endif

  assign p_data     = p_data_q;
  assign data_valid = data_valid_q;
  assign stp_err    = stp_err_q;
  assign strt_err   = strt_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [4:0] prescale;
  logic       sampled_bit;
`ifdef UART_RX_PARITY_EN
  logic       par_en;
  logic       par_typ;
`endif
  logic [4:0] edge_cnt;
  logic       dat_samp_en;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, strt_err;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .sampled_bit (sampled_bit),
`ifdef UART_RX_PARITY_EN
    .par_en      (par_en),
    .par_typ     (par_typ),
`endif
    .edge_cnt    (edge_cnt),
    .dat_samp_en (dat_samp_en),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .strt_err    (strt_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 3-sample majority sampler around the bit centre.
  logic s0 = 1'b1, s1 = 1'b1, s2 = 1'b1;
  always @(posedge clk) begin
    if (dat_samp_en) begin
      if (int'(edge_cnt) == int'(prescale) / 2 - 1) s0 <= rx_in;
      if (int'(edge_cnt) == int'(prescale) / 2)     s1 <= rx_in;
      if (int'(edge_cnt) == int'(prescale) / 2 + 1) s2 <= rx_in;
    end
  end
  assign sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);

  // Pulse monitor: records the cycle of every strobe.
  int         dv_q[$], pe_q[$], se_q[$], st_q[$];
  logic [7:0] pd_q[$];
  always @(negedge clk) begin
    if (data_valid) begin dv_q.push_back(cyc); pd_q.push_back(p_data); end
    if (par_err)  pe_q.push_back(cyc);
    if (stp_err)  se_q.push_back(cyc);
    if (strt_err) st_q.push_back(cyc);
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    dv_q.delete(); pe_q.delete(); se_q.delete(); st_q.delete(); pd_q.delete();
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one full frame starting in the current cycle; tracks edge_cnt/dat_samp_en.
  task automatic send(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                      input bit pbit, input bit stop, output int n0);
    logic [11:0] bits;
    int nb, k, bad;
    prescale = 5'(p);
`ifdef UART_RX_PARITY_EN
    par_en  = pen;
    par_typ = ptyp;
`endif
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nb = 9;
    if (pen) begin bits[nb] = pbit; nb++; end
    bits[nb] = stop; nb++;
    n0 = cyc; k = 0; bad = 0;
    for (int b = 0; b < nb; b++) begin
      rx_in = bits[b];
      repeat (p) begin
        if (int'(edge_cnt) != k % p) bad++;
        if (dat_samp_en != (k != 0)) bad++;
        k++;
        @(posedge clk);
        #1;
      end
    end
    chk("edge_track", bad, 0);
  endtask

  task automatic outcome(input string nm, input int n0, input int lat, input logic [7:0] d,
                         input bit e_dv, input bit e_pe, input bit e_se);
    idle(2);
    if (e_dv) last_good = d;
    chk({nm, ".dv_n"}, dv_q.size(), 32'(e_dv));
    chk({nm, ".pe_n"}, pe_q.size(), 32'(e_pe));
    chk({nm, ".se_n"}, se_q.size(), 32'(e_se));
    chk({nm, ".st_n"}, st_q.size(), 0);
    if (dv_q.size() == 1) begin
      chk({nm, ".dv_cyc"}, dv_q[0] - n0, lat);
      chk({nm, ".dv_data"}, pd_q[0], d);
    end
    if (pe_q.size() == 1) chk({nm, ".pe_cyc"}, pe_q[0] - n0, lat);
    if (se_q.size() == 1) chk({nm, ".se_cyc"}, se_q[0] - n0, lat);
    chk({nm, ".p_data"}, p_data, last_good);
    clear_q();
  endtask

  typedef struct {
    int p; bit pen; bit ptyp; logic [7:0] d; bit pbit; bit stop;
    bit e_dv; bit e_pe; bit e_se; int e_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n0, n1, p, lat;
    bit pen, ptyp, pbit, stop, e_pe, e_se;
    logic [7:0] d;

    vecs.push_back('{8,  0, 0, 8'hA5, 0, 1, 1, 0, 0, 80});
    vecs.push_back('{8,  0, 0, 8'h81, 0, 0, 0, 0, 1, 80});
    vecs.push_back('{16, 0, 0, 8'h5A, 0, 1, 1, 0, 0, 160});
    vecs.push_back('{16, 0, 0, 8'h00, 0, 0, 0, 0, 1, 160});
    vecs.push_back('{8,  0, 0, 8'hFF, 0, 1, 1, 0, 0, 80});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8,  1, 0, 8'h0F, 1, 1, 0, 1, 0, 88});
    vecs.push_back('{8,  1, 1, 8'h0F, 1, 1, 1, 0, 0, 88});
    vecs.push_back('{8,  1, 0, 8'h07, 0, 0, 0, 1, 1, 88});
    vecs.push_back('{16, 1, 0, 8'h33, 0, 1, 1, 0, 0, 176});
    par_en  = 1'b0;
    par_typ = 1'b0;
`endif

    rst = 1'b1; rx_in = 1'b1; prescale = 5'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.edge_cnt", edge_cnt, 0);
    chk("rst.samp_en", dat_samp_en, 0);
    chk("rst.p_data", p_data, 0);
    chk("rst.strobes", {data_valid, par_err, stp_err, strt_err}, 0);
    rst = 1'b0;
    idle(3);
    clear_q();

    // Vector table.
    foreach (vecs[i]) begin
      send(vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].d, vecs[i].pbit, vecs[i].stop, n0);
      outcome($sformatf("vec%0d", i), n0, vecs[i].e_lat, vecs[i].d,
              vecs[i].e_dv, vecs[i].e_pe, vecs[i].e_se);
    end

    // Start glitch: line low for two cycles only.
    prescale = 5'd8;
    n0 = cyc;
    rx_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(10);
    chk("glitch.st_n", st_q.size(), 1);
    if (st_q.size() == 1) chk("glitch.st_cyc", st_q[0] - n0, 8);
    chk("glitch.dv_n", dv_q.size(), 0);
    chk("glitch.idle", dat_samp_en, 0);
    clear_q();
    send(8, 0, 0, 8'h3C, 0, 1, n0);
    outcome("after_glitch", n0, 80, 8'h3C, 1, 0, 0);

    // Back-to-back frames at P=16 with zero idle.
    send(16, 0, 0, 8'h55, 0, 1, n0);
    send(16, 0, 0, 8'h3C, 0, 1, n1);
    idle(2);
    chk("b2b.dv_n", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      chk("b2b.first_cyc", dv_q[0] - n0, 160);
      chk("b2b.spacing", dv_q[1] - dv_q[0], 160);
      chk("b2b.data0", pd_q[0], 8'h55);
      chk("b2b.data1", pd_q[1], 8'h3C);
    end
    last_good = 8'h3C;
    clear_q();

    // Reset in the middle of data bit 3.
    prescale = 5'd8;
    d = 8'h96;
    rx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      rx_in = d[b];
      repeat (8) @(posedge clk);
      #1;
    end
    rx_in = d[3];
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.busy", dat_samp_en, 1);
    rst = 1'b1;
    #1;
    chk("midrst.edge_cnt", edge_cnt, 0);
    chk("midrst.samp_en", dat_samp_en, 0);
    chk("midrst.p_data", p_data, 0);
    chk("midrst.strobes", {data_valid, par_err, stp_err, strt_err}, 0);
    last_good = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    clear_q();
    send(8, 0, 0, 8'hC3, 0, 1, n0);
    outcome("after_rst", n0, 80, 8'hC3, 1, 0, 0);

    // Randomized frames against the frame-level model.
    for (int t = 0; t < 24; t++) begin
      p    = ($urandom_range(0, 1) == 1) ? 16 : 8;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pen  = 1'b0; ptyp = 1'b0; pbit = 1'b0;
`ifdef UART_RX_PARITY_EN
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      pbit = ($urandom_range(0, 3) == 0) ? ~((^d) ^ ptyp) : ((^d) ^ ptyp);
`endif
      // Expected parity bit is XOR of data bits, inverted for odd parity.
      e_se = !stop;
      e_pe = pen && (pbit != ((^d) ^ ptyp));
      lat  = (10 + int'(pen)) * p;
      send(p, pen, ptyp, d, pbit, stop, n0);
      outcome($sformatf("rand%0d", t), n0, lat, d, !e_se && !e_pe, e_pe, e_se);
      idle($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
